// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner
//  Purpose  : Conditions raw board push-buttons for downstream lab blocks.
//             Per key: two-flop synchroniser, polarity normalisation,
//             counter-based debounce, and one-cycle press/release pulses.
//  Ports    : clkI        - system clock, all logic on rising edge
//             rstI        - synchronous active-high reset
//             keyI        - raw asynchronous button pins (N_KEYS)
//             keyLevelO   - debounced level, 1 = pressed (N_KEYS)
//             keyPressO   - one-cycle pulse on accepted press / auto-repeat
//             keyReleaseO - one-cycle pulse on accepted release
//             anyPressO   - OR of keyPressO
//  Options  : define KEY_REPEAT_EN to add per-key hold-to-repeat press pulses
//             (REPEAT_DELAY to the first repeat, REPEAT_PERIOD thereafter).
//  Revision : 1.0 - initial release
// ============================================================================

module key_conditioner #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int KEY_ACTIVE_LOW  = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              clkI,
   input  logic              rstI,
   input  logic [N_KEYS-1:0] keyI,
   output logic [N_KEYS-1:0] keyLevelO,
   output logic [N_KEYS-1:0] keyPressO,
   output logic [N_KEYS-1:0] keyReleaseO,
   output logic              anyPressO
);

   // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Pin level of an idle (released) button; the synchroniser resets to it
   // so that leaving reset never looks like an edge.
   localparam logic RELEASED_LVL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

`ifdef KEY_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
   localparam logic [HOLD_W-1:0] HOLD_DLY_END = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_PER_END = HOLD_W'(REPEAT_PERIOD - 1);
`endif

   // Elaboration-time guard against illegal configurations.
   generate
      if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
         $error("key_conditioner: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         logic             sync1_q;
         logic             sync2_q;
         logic             raw;
         logic             differ;
         logic             accept;
         logic             release_acc;
         logic             rep_fire;
         logic             stable_q, stable_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             press_q, press_d;
         logic             rel_q, rel_d;

         // Normalise after the second flop: raw = 1 means pressed.
         assign raw    = sync2_q ^ RELEASED_LVL;
         assign differ = raw ^ stable_q;

         // A new level is accepted on the edge where it has disagreed with
         // the stable level for DEBOUNCE_CYCLES consecutive samples.
         assign accept      = differ && (cnt_q == CNT_MAX);
         assign release_acc = accept && !raw;

         always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (accept) begin
               stable_d = raw;
            end else if (differ) begin
               cnt_d = cnt_q + 1'b1;
            end
            // Any sample matching stable clears cnt: glitches get no credit.
         end

`ifdef KEY_REPEAT_EN
         logic [HOLD_W-1:0] hold_q, hold_d;
         logic              rep_phase_q, rep_phase_d;

         // rep_phase_q = 0 while waiting for the first repeat (REPEAT_DELAY),
         // 1 while producing periodic repeats (REPEAT_PERIOD). The counter
         // restarts at each repeat so it never exceeds the larger interval.
         always_comb begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
            rep_fire    = 1'b0;
            if (stable_q && !release_acc) begin
               if ((!rep_phase_q && hold_q == HOLD_DLY_END) ||
                   ( rep_phase_q && hold_q == HOLD_PER_END)) begin
                  rep_fire    = 1'b1;
                  hold_d      = '0;
                  rep_phase_d = 1'b1;
               end else begin
                  hold_d      = hold_q + 1'b1;
                  rep_phase_d = rep_phase_q;
               end
            end
         end

         always_ff @(posedge clkI) begin
            if (rstI) begin
               hold_q      <= '0;
               rep_phase_q <= 1'b0;
            end else begin
               hold_q      <= hold_d;
               rep_phase_q <= rep_phase_d;
            end
         end
`else
         assign rep_fire = 1'b0;
`endif

         // Press acceptance needs stable_q = 0 while a repeat needs
         // stable_q = 1, so the two sources never collide.
         assign press_d = (accept && raw) || rep_fire;
         assign rel_d   = release_acc;

         always_ff @(posedge clkI) begin
            if (rstI) begin
               sync1_q  <= RELEASED_LVL;
               sync2_q  <= RELEASED_LVL;
               stable_q <= 1'b0;
               cnt_q    <= '0;
               press_q  <= 1'b0;
               rel_q    <= 1'b0;
            end else begin
               sync1_q  <= keyI[gi];
               sync2_q  <= sync1_q;
               stable_q <= stable_d;
               cnt_q    <= cnt_d;
               press_q  <= press_d;
               rel_q    <= rel_d;
            end
         end

         assign keyLevelO[gi]   = stable_q;
         assign keyPressO[gi]   = press_q;
         assign keyReleaseO[gi] = rel_q;
      end
   endgenerate

   assign anyPressO = |keyPressO;

endmodule

`default_nettype wire
